// File: rtl/requan_ctrl_if.sv
// requan_ctrl_if: groups the sample stream, power-table and multiplier signals
// of the requantizer sequencer. The slave modport is the controller's view and
// the master modport is the surrounding datapath/environment view.
interface requan_ctrl_if #(
  parameter int unsigned ROM_AW = 10
);
  // Upstream sample stream
  logic              in_valid;
  logic              in_ready;
  logic [15:0]       in_is;
  logic [15:0]       gain_mant;
  logic [3:0]        gain_shift;
  // Power table
  logic [ROM_AW-1:0] rom_addr;
  logic [19:0]       rom_data;
  // Multiplier
  logic [15:0]       mult_a;
  logic [15:0]       mult_b;
  logic [15:0]       mult_in;
  // Downstream sample stream
  logic              out_valid;
  logic              out_ready;
  logic [15:0]       out_data;
  // Granule bookkeeping
  logic [9:0]        sample_idx;
  logic              granule_done;

  modport slave (
    input  in_valid, in_is, gain_mant, gain_shift, rom_data, mult_in, out_ready,
    output in_ready, rom_addr, mult_a, mult_b, out_valid, out_data, sample_idx,
           granule_done
  );

  modport master (
    output in_valid, in_is, gain_mant, gain_shift, rom_data, mult_in, out_ready,
    input  in_ready, rom_addr, mult_a, mult_b, out_valid, out_data, sample_idx,
           granule_done
  );
endinterface

// File: rtl/requan_ctrl.sv
// requan_ctrl: sequences one Huffman-decoded sample at a time through the
// |is|^(4/3) power table and the external multiplier, applies exponent, gain
// shift and sign, and hands the 16-bit result downstream.
// Optional feature macro: REQUAN_SAT_EN (defined: saturate the result to
// 16 bits; undefined: keep the low 16 bits, two's-complement wrap).
module requan_ctrl #(
  parameter int unsigned ROM_AW      = 10,
  parameter int unsigned GRANULE_LEN = 576
) (
  input logic          clk,
  input logic          rst,
  requan_ctrl_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StRom, StMul, StOut} state_e;

  localparam logic [15:0] RomMax  = 16'((32'd1 << ROM_AW) - 32'd1);
  localparam logic [9:0]  LastIdx = 10'(GRANULE_LEN - 1);

  state_e            state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic              sign_q, sign_d;
  logic              zero_q, zero_d;
  logic [15:0]       gain_mant_q, gain_mant_d;
  logic [3:0]        gain_shift_q, gain_shift_d;
  logic [ROM_AW-1:0] rom_addr_q, rom_addr_d;
  logic [15:0]       mult_b_q, mult_b_d;
  logic              out_valid_q, out_valid_d;
  logic [15:0]       out_data_q, out_data_d;
  logic [9:0]        sample_idx_q, sample_idx_d;
  logic              granule_done_q, granule_done_d;

  logic              accept;
  logic              out_hs;
  logic [15:0]       abs_is;
  logic [ROM_AW-1:0] addr_clamp;
  logic [3:0]        rom_exp;
  logic [15:0]       rom_mant;
  logic signed [31:0] p_ext;
  logic signed [31:0] p_shl;
  logic [15:0]       sample_out;
`ifdef REQUAN_SAT_EN
  logic signed [31:0] p_scaled;
  logic signed [31:0] p_signed;
`else
  logic [15:0]       p_low;
`endif

  assign rom_exp  = bus.rom_data[19:16];
  assign rom_mant = bus.rom_data[15:0];

  // in_ready_q gates acceptance so nothing is taken in the cycle reset releases.
  assign accept = (state_q == StIdle) && in_ready_q && bus.in_valid;
  assign out_hs = (state_q == StOut) && bus.out_ready;

  // Magnitude of the incoming sample, clamped to the last table entry.
  always_comb begin
    abs_is     = bus.in_is[15] ? (~bus.in_is + 16'd1) : bus.in_is;
    addr_clamp = (abs_is > RomMax) ? '1 : abs_is[ROM_AW-1:0];
  end

  // Scale the product by the table exponent and gain shift, then apply sign/zero.
  always_comb begin
    p_ext = {{16{bus.mult_in[15]}}, bus.mult_in};
    p_shl = p_ext <<< rom_exp;
`ifdef REQUAN_SAT_EN
    p_scaled = p_shl >>> gain_shift_q;
    p_signed = sign_q ? -p_scaled : p_scaled;
    if (zero_q) begin
      sample_out = '0;
    end else if (p_signed > 32'sd32767) begin
      sample_out = 16'h7fff;
    end else if (p_signed < -32'sd32768) begin
      sample_out = 16'h8000;
    end else begin
      sample_out = p_signed[15:0];
    end
`else
    // Only the low half survives, and negation of the low half needs no upper bits.
    p_low = 16'(p_shl >>> gain_shift_q);
    if (zero_q) begin
      sample_out = '0;
    end else begin
      sample_out = sign_q ? -p_low : p_low;
    end
`endif
  end

  // Next-state and next-output logic for the four-phase sample sequence.
  always_comb begin
    state_d        = state_q;
    sign_d         = sign_q;
    zero_d         = zero_q;
    gain_mant_d    = gain_mant_q;
    gain_shift_d   = gain_shift_q;
    rom_addr_d     = rom_addr_q;
    out_valid_d    = out_valid_q;
    out_data_d     = out_data_q;
    sample_idx_d   = sample_idx_q;
    granule_done_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          sign_d       = bus.in_is[15];
          zero_d       = (bus.in_is == 16'd0);
          gain_mant_d  = bus.gain_mant;
          gain_shift_d = bus.gain_shift;
          rom_addr_d   = addr_clamp;
          state_d      = StRom;
        end
      end
      StRom: begin
        state_d = StMul;
      end
      StMul: begin
        out_data_d  = sample_out;
        out_valid_d = 1'b1;
        state_d     = StOut;
      end
      StOut: begin
        if (out_hs) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
          if (sample_idx_q == LastIdx) begin
            sample_idx_d   = '0;
            granule_done_d = 1'b1;
          end else begin
            sample_idx_d = sample_idx_q + 10'd1;
          end
        end
      end
    endcase

    in_ready_d = (state_d == StIdle);
    // Gain operand is presented only while the table output is valid.
    mult_b_d   = (state_d == StMul) ? gain_mant_q : '0;
  end

  // State and output registers; reset abandons any sample in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= StIdle;
      in_ready_q     <= 1'b0;
      sign_q         <= 1'b0;
      zero_q         <= 1'b0;
      gain_mant_q    <= '0;
      gain_shift_q   <= '0;
      rom_addr_q     <= '0;
      mult_b_q       <= '0;
      out_valid_q    <= 1'b0;
      out_data_q     <= '0;
      sample_idx_q   <= '0;
      granule_done_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      in_ready_q     <= in_ready_d;
      sign_q         <= sign_d;
      zero_q         <= zero_d;
      gain_mant_q    <= gain_mant_d;
      gain_shift_q   <= gain_shift_d;
      rom_addr_q     <= rom_addr_d;
      mult_b_q       <= mult_b_d;
      out_valid_q    <= out_valid_d;
      out_data_q     <= out_data_d;
      sample_idx_q   <= sample_idx_d;
      granule_done_q <= granule_done_d;
    end
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.rom_addr     = rom_addr_q;
  // Table data only arrives in MUL, so this operand is a gated pass-through.
  assign bus.mult_a       = (state_q == StMul) ? rom_mant : '0;
  assign bus.mult_b       = mult_b_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_data     = out_data_q;
  assign bus.sample_idx   = sample_idx_q;
  assign bus.granule_done = granule_done_q;

endmodule
